// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator feeding the frame-buffer read stage. The scan
//   coordinates leave undelayed to form the frame-buffer address; the sync
//   and active-video flags are delayed by SYNC_DELAY stages so they line up
//   with the RGB the frame buffer returns.
//
// Optional feature (macro VGA_PIX_CE_EN):
//   defined   -> adds input pix_ce; counters and delay stages advance only
//                on edges with pix_ce=1 (rst still overrides).
//   undefined -> no pix_ce port, everything advances every clock.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous, active-high reset
//   pix_ce       in   pixel clock enable (only with VGA_PIX_CE_EN)
//   pixel_x      out  [10:0] horizontal count, undelayed
//   pixel_y      out  [9:0]  vertical count, undelayed
//   frame_start  out  high while pixel_x==0 && pixel_y==0 and not in reset
//   hsync_o      out  horizontal sync, delayed SYNC_DELAY
//   vsync_o      out  vertical sync, delayed SYNC_DELAY
//   video_on_o   out  active-video flag, delayed SYNC_DELAY
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned H_VIS      = 1024,
   parameter int unsigned H_FP       = 24,
   parameter int unsigned H_SYNC     = 136,
   parameter int unsigned H_BP       = 160,
   parameter int unsigned V_VIS      = 768,
   parameter int unsigned V_FP       = 3,
   parameter int unsigned V_SYNC     = 6,
   parameter int unsigned V_BP       = 29,
   parameter logic        H_POL      = 1'b0,
   parameter logic        V_POL      = 1'b0,
   parameter int unsigned SYNC_DELAY = 2
) (
   input  logic        clk,
   input  logic        rst,
`ifdef VGA_PIX_CE_EN
   input  logic        pix_ce,
`endif
   output logic [10:0] pixel_x,
   output logic [9:0]  pixel_y,
   output logic        frame_start,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        video_on_o
);

   localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_VIS + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;  // exclusive
   localparam int unsigned VS_START = V_VIS + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;  // exclusive

   generate
      if (H_TOTAL > 2048) begin : g_bad_h_total
         $error("vga_timing_gen: H_TOTAL exceeds 2048");
      end
      if (V_TOTAL > 1024) begin : g_bad_v_total
         $error("vga_timing_gen: V_TOTAL exceeds 1024");
      end
      if (SYNC_DELAY > 4) begin : g_bad_delay
         $error("vga_timing_gen: SYNC_DELAY exceeds 4");
      end
   endgenerate

   logic ce;
`ifdef VGA_PIX_CE_EN
   assign ce = pix_ce;
`else
   assign ce = 1'b1;
`endif

   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (ce) begin
         if (h_cnt == 11'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == 10'(V_TOTAL - 1)) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   assign pixel_x     = h_cnt;
   assign pixel_y     = v_cnt;
   assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !rst;

   // One extra bit so bounds equal to 2048 / 1024 still compare correctly.
   logic [11:0] hx;
   logic [10:0] vx;
   logic        hs_act, vs_act, vid, hs, vs;

   assign hx     = {1'b0, h_cnt};
   assign vx     = {1'b0, v_cnt};
   assign hs_act = (hx >= 12'(HS_START)) && (hx < 12'(HS_END));
   assign vs_act = (vx >= 11'(VS_START)) && (vx < 11'(VS_END));
   assign vid    = (hx < 12'(H_VIS)) && (vx < 11'(V_VIS));
   assign hs     = hs_act ? H_POL : ~H_POL;
   assign vs     = vs_act ? V_POL : ~V_POL;

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign hsync_o    = hs;
         assign vsync_o    = vs;
         assign video_on_o = vid;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe, vid_pipe;

         // Shift in at bit 0; truncating {pipe, in} drops the oldest stage,
         // which keeps SYNC_DELAY=1 free of negative slice bounds.
         always_ff @(posedge clk) begin
            if (rst) begin
               hs_pipe  <= {SYNC_DELAY{~H_POL}};
               vs_pipe  <= {SYNC_DELAY{~V_POL}};
               vid_pipe <= '0;
            end else if (ce) begin
               hs_pipe  <= SYNC_DELAY'({hs_pipe, hs});
               vs_pipe  <= SYNC_DELAY'({vs_pipe, vs});
               vid_pipe <= SYNC_DELAY'({vid_pipe, vid});
            end
         end

         assign hsync_o    = hs_pipe[SYNC_DELAY-1];
         assign vsync_o    = vs_pipe[SYNC_DELAY-1];
         assign video_on_o = vid_pipe[SYNC_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generators share clk/rst/pix_ce: default 1024x768 timing with
//   SYNC_DELAY=2, default timing with SYNC_DELAY=0, and a tiny raster
//   (24x11 total, positive hsync, SYNC_DELAY=3) that wraps whole frames
//   quickly. Expected outputs come from a closed-form model of the number of
//   enabled edges since reset, queued when stimulus is driven and compared
//   on the following falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic pix_ce = 1'b1;

`ifdef VGA_PIX_CE_EN
   localparam bit CE_EN = 1'b1;
`else
   localparam bit CE_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      int h_vis; int h_fp; int h_sync; int h_bp;
      int v_vis; int v_fp; int v_sync; int v_bp;
      int h_pol; int v_pol; int dly;
   } tcfg_t;

   localparam tcfg_t CFG_DEF = '{1024, 24, 136, 160, 768, 3, 6, 29, 0, 0, 2};
   localparam tcfg_t CFG_D0  = '{1024, 24, 136, 160, 768, 3, 6, 29, 0, 0, 0};
   localparam tcfg_t CFG_SML = '{16, 2, 3, 3, 6, 1, 2, 2, 1, 0, 3};

   typedef struct packed {
      logic [10:0] px;
      logic [9:0]  py;
      logic        fs;
      logic        hs;
      logic        vs;
      logic        vid;
   } obs_t;

   typedef struct packed {
      int   k;
      logic rstv;
      obs_t e_def;
      obs_t e_d0;
      obs_t e_sml;
   } exp_t;

   exp_t sb[$];

   logic [10:0] def_px, d0_px, sml_px;
   logic [9:0]  def_py, d0_py, sml_py;
   logic        def_fs, def_hs, def_vs, def_vid;
   logic        d0_fs, d0_hs, d0_vs, d0_vid;
   logic        sml_fs, sml_hs, sml_vs, sml_vid;

   vga_timing_gen u_def (
      .clk         (clk),
      .rst         (rst),
`ifdef VGA_PIX_CE_EN
      .pix_ce      (pix_ce),
`endif
      .pixel_x     (def_px),
      .pixel_y     (def_py),
      .frame_start (def_fs),
      .hsync_o     (def_hs),
      .vsync_o     (def_vs),
      .video_on_o  (def_vid)
   );

   vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
      .clk         (clk),
      .rst         (rst),
`ifdef VGA_PIX_CE_EN
      .pix_ce      (pix_ce),
`endif
      .pixel_x     (d0_px),
      .pixel_y     (d0_py),
      .frame_start (d0_fs),
      .hsync_o     (d0_hs),
      .vsync_o     (d0_vs),
      .video_on_o  (d0_vid)
   );

   vga_timing_gen #(
      .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VIS(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
      .H_POL(1'b1), .V_POL(1'b0), .SYNC_DELAY(3)
   ) u_sml (
      .clk         (clk),
      .rst         (rst),
`ifdef VGA_PIX_CE_EN
      .pix_ce      (pix_ce),
`endif
      .pixel_x     (sml_px),
      .pixel_y     (sml_py),
      .frame_start (sml_fs),
      .hsync_o     (sml_hs),
      .vsync_o     (sml_vs),
      .video_on_o  (sml_vid)
   );

   int n_cmp   = 0;
   int n_err   = 0;
   int cur_k   = 0;
   int k_model = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s k=%0d: got %0d, expected %0d", tag, cur_k, got, exp);
      end
   endtask

   // Outputs after k enabled edges since reset; delayed flags show the
   // raster position of k-dly, or the idle levels before the pipe fills.
   function automatic obs_t model(input tcfg_t c, input int k, input bit r);
      obs_t o;
      int ht, vt, h, v, kd, hd, vd;
      ht   = c.h_vis + c.h_fp + c.h_sync + c.h_bp;
      vt   = c.v_vis + c.v_fp + c.v_sync + c.v_bp;
      h    = k % ht;
      v    = (k / ht) % vt;
      o.px = 11'(h);
      o.py = 10'(v);
      o.fs = (h == 0) && (v == 0) && !r;
      if (k < c.dly) begin
         o.hs  = ~c.h_pol[0];
         o.vs  = ~c.v_pol[0];
         o.vid = 1'b0;
      end else begin
         kd    = k - c.dly;
         hd    = kd % ht;
         vd    = (kd / ht) % vt;
         o.hs  = (hd >= c.h_vis + c.h_fp && hd < c.h_vis + c.h_fp + c.h_sync)
                 ? c.h_pol[0] : ~c.h_pol[0];
         o.vs  = (vd >= c.v_vis + c.v_fp && vd < c.v_vis + c.v_fp + c.v_sync)
                 ? c.v_pol[0] : ~c.v_pol[0];
         o.vid = (hd < c.h_vis) && (vd < c.v_vis);
      end
      return o;
   endfunction

   task automatic cmp_obs(input string pfx, input obs_t got, input obs_t exp, input bit skip_vid);
      check({pfx, ".pixel_x"},     32'(got.px), 32'(exp.px));
      check({pfx, ".pixel_y"},     32'(got.py), 32'(exp.py));
      check({pfx, ".frame_start"}, 32'(got.fs), 32'(exp.fs));
      check({pfx, ".hsync"},       32'(got.hs), 32'(exp.hs));
      check({pfx, ".vsync"},       32'(got.vs), 32'(exp.vs));
      if (!skip_vid)
         check({pfx, ".video_on"}, 32'(got.vid), 32'(exp.vid));
   endtask

   // Called right after a rising edge: drives this cycle's inputs, queues
   // what the DUTs must show during it, then advances the model.
   task automatic cycle(input bit r, input bit ce);
      exp_t e;
      #1;
      rst     = r;
      pix_ce  = ce;
      e.k     = k_model;
      e.rstv  = r;
      e.e_def = model(CFG_DEF, k_model, r);
      e.e_d0  = model(CFG_D0,  k_model, r);
      e.e_sml = model(CFG_SML, k_model, r);
      sb.push_back(e);
      if (r)
         k_model = 0;
      else if (ce || !CE_EN)
         k_model++;
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e     = sb.pop_front();
            cur_k = e.k;
            cmp_obs("def", {def_px, def_py, def_fs, def_hs, def_vs, def_vid}, e.e_def, 1'b0);
            // video_on with zero delay during reset is a pass-through of
            // the cleared counters; only its post-reset behaviour is checked.
            cmp_obs("d0",  {d0_px, d0_py, d0_fs, d0_hs, d0_vs, d0_vid},       e.e_d0,  e.rstv);
            cmp_obs("sml", {sml_px, sml_py, sml_fs, sml_hs, sml_vs, sml_vid}, e.e_sml, 1'b0);
         end
      end
   end

   initial begin : driver
      @(posedge clk);
      repeat (5) cycle(1'b1, 1'b1);
      // Two full default lines plus part of line 2, ending inside an hsync pulse.
      repeat (3788) cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      repeat (2800) cycle(1'b0, 1'b1);
      // Alternating enable, then a held-off stretch.
      for (int i = 0; i < 1500; i++) cycle(1'b0, (i % 2) == 0);
      repeat (10) cycle(1'b0, 1'b0);
      repeat (200) cycle(1'b0, 1'b1);
      // Reset must win over a low enable.
      cycle(1'b1, 1'b0);
      repeat (300) cycle(1'b0, 1'b1);
      @(negedge clk);
      #1;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of the frame-buffer read stage.
- Produces the pixel_x/pixel_y scan coordinates that drive the frame-buffer address.
- Produces hsync/vsync/video_on, delayed by SYNC_DELAY cycles so they line up with the RGB the frame buffer returns two clocks after the coordinates.
- Default timing: 1024x768 @ 60 Hz (65 MHz pixel clock).

Parameters:
H_VIS, 1024, visible pixels per line
H_FP, 24, horizontal front porch (clocks)
H_SYNC, 136, hsync pulse width
H_BP, 160, horizontal back porch
V_VIS, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vsync pulse width
V_BP, 29, vertical back porch
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
SYNC_DELAY, 2, register stages on hsync/vsync/video_on (legal 0..4); 2 matches frame-buffer read latency

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
pixel_x  out  11  horizontal count, undelayed (to frame-buffer address)
pixel_y  out  10  vertical count, undelayed
frame_start  out  1  high while pixel_x==0 && pixel_y==0
hsync_o  out  1  horizontal sync, delayed SYNC_DELAY
vsync_o  out  1  vertical sync, delayed SYNC_DELAY
video_on_o  out  1  active-video flag, delayed SYNC_DELAY

Behaviour:
- One clock: clk. Reset: rst, synchronous, active-high. All state clears on the clk edge where rst=1.
- Derived constants:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (1344)
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (806)
  - Elaboration error if H_TOTAL>2048, V_TOTAL>1024, or SYNC_DELAY>4.
- Counters h_cnt (11b) and v_cnt (10b), registered:
  - h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the h_cnt wrap, and wraps V_TOTAL-1 -> 0 on that same edge.
- pixel_x = h_cnt and pixel_y = v_cnt, direct register outputs. Full blanking range is emitted; no clamping.
- Internal decodes, combinational from the counters:
  - hs_act = h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]
  - vs_act = v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]
  - vid = (h_cnt<H_VIS) && (v_cnt<V_VIS)
- Sync levels: hs = hs_act ? H_POL : ~H_POL; vs likewise with V_POL.
- Delay line: hs, vs and vid each pass through SYNC_DELAY registers to give hsync_o, vsync_o, video_on_o. SYNC_DELAY=0 means a combinational pass-through.
- frame_start: combinational (h_cnt==0 && v_cnt==0) && !rst. It is aligned with the coordinates, not with the delayed syncs.
- Reset values:
  - h_cnt=0, v_cnt=0, so pixel_x=0 and pixel_y=0.
  - Every delay stage loads the inactive value (hsync ~H_POL, vsync ~V_POL, video_on 0).
  - hsync_o=~H_POL, vsync_o=~V_POL, video_on_o=0, frame_start=0.
- Cycle numbering: let n=0 be the first cycle with rst low. Then h_cnt = n mod H_TOTAL.
  - Output delay-stage contents are the reset values until the pipeline fills at n = SYNC_DELAY.
- Reset mid-frame: on the next edge, counters return to 0 and the delay pipelines clear. No partial sync pulse continues past that edge.
- Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on the same edge, and frame_start asserts the following cycle.

Optional Feature:
- Macro: VGA_PIX_CE_EN.
- Defined:
  - Adds port pix_ce (in, 1) after rst.
  - Counters and all delay stages advance only on edges where pix_ce=1; otherwise everything holds.
  - SYNC_DELAY counts pix_ce-qualified edges.
  - rst overrides pix_ce.
  - frame_start stays combinational (it is not gated by pix_ce).
- Undefined: no pix_ce port; behaviour is as if pix_ce=1 constantly.

Test Plan:
1. Hold rst=1 for 5 clocks -> pixel_x=0, pixel_y=0, hsync_o=1, vsync_o=1, video_on_o=0, frame_start=0 throughout.
2. Release rst, run 2 lines (defaults) -> pixel_x counts 0..1343 and wraps, pixel_y steps 0->1 at n=1344. hsync_o is low for exactly n=1050..1185 (136 clocks) and again at 2394..2529.
3. Run 1 frame -> video_on_o high n=2..1025 on line 0, 1024 clocks per line, low from line 768 onward. vsync_o low while lines 771..776 emerge (n=771*1344+2 through 777*1344+1). frame_start pulses at n=0 and n=1083264.
4. Assert rst for 1 clock at pixel (500,300) -> next cycle pixel_x=0, pixel_y=0, hsync_o/vsync_o=1, video_on_o=0. Timing then resumes from n=0 exactly as in scenario 2.
5. SYNC_DELAY=0 -> hsync_o low for exactly pixel_x 1048..1183. video_on_o equals (pixel_x<1024 && pixel_y<768) in the same cycle.
6. VGA_PIX_CE_EN, pix_ce toggling 1,0,1,0 -> pixel_x advances every other clock, and one line takes 2688 clocks. With pix_ce=0 held 10 clocks, all outputs are frozen.
